// File: rtl/controle_servo_multi.sv
// Multi-channel servo PWM driver: one shared period counter, per-channel latched
// target/enable, slew-limited applied position and settle flag.
module controle_servo_multi #(
    parameter int unsigned N           = 2,
    parameter int unsigned W           = 8,
    parameter int unsigned PERIODO     = 1_000_000,
    parameter int unsigned LARGURA_MIN = 50_000,
    parameter int unsigned PASSO       = 196,
    parameter int unsigned RAMPA       = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [N*W-1:0]   posicao_i,
    input  logic [N-1:0]     habilita_i,
    output logic [N-1:0]     sinal_controle_o,
    output logic [N-1:0]     pronto_o,
    output logic             fim_periodo_o
);

    localparam int unsigned CW = (PERIODO > 1) ? $clog2(PERIODO) : 1;
    localparam int unsigned LW = $clog2(PERIODO + 1);
    localparam logic [CW-1:0] ULTIMO = CW'(PERIODO - 1);
    // Saturate the ramp step so it always fits in W+1 bits; a step of 2^W or
    // more behaves exactly like "jump directly".
    localparam int unsigned RAMPA_SAT = (RAMPA >= (1 << W)) ? (1 << W) : RAMPA;
    localparam logic [W:0]    RAMPA_W = (W+1)'(RAMPA_SAT);
    localparam logic [LW-1:0] LMIN_W  = LW'(LARGURA_MIN);
    localparam logic [LW-1:0] PASSO_W = LW'(PASSO);

    logic [CW-1:0] contador_q, contador_d;
    logic          fim_q, fim_d;
    logic          fronteira;

    logic [W-1:0]  atual_q   [N];
    logic [W-1:0]  atual_d   [N];
    logic [W-1:0]  alvo_q    [N];
    logic [W-1:0]  alvo_d    [N];
    logic [LW-1:0] largura_q [N];
    logic [LW-1:0] largura_d [N];
    logic [N-1:0]  hab_q, hab_d;
    logic [N-1:0]  sinal_q, sinal_d;
    logic [N-1:0]  pronto_q, pronto_d;

    function automatic logic [W-1:0] passo_rampa(input logic [W-1:0] atual,
                                                 input logic [W-1:0] alvo);
        logic [W:0] dif;
        if (alvo >= atual) begin
            dif = {1'b0, alvo} - {1'b0, atual};
            if (RAMPA == 0 || dif <= RAMPA_W) return alvo;
            return atual + RAMPA_W[W-1:0];
        end
        dif = {1'b0, atual} - {1'b0, alvo};
        if (RAMPA == 0 || dif <= RAMPA_W) return alvo;
        return atual - RAMPA_W[W-1:0];
    endfunction

    always_comb begin
        fronteira  = (contador_q == ULTIMO);
        contador_d = fronteira ? '0 : contador_q + CW'(1);
        fim_d      = (contador_d == ULTIMO);
        hab_d      = hab_q;
        pronto_d   = pronto_q;
        sinal_d    = '0;
        for (int i = 0; i < N; i++) begin
            alvo_d[i]    = alvo_q[i];
            atual_d[i]   = atual_q[i];
            largura_d[i] = largura_q[i];
            if (fronteira) begin
                alvo_d[i]    = posicao_i[i*W +: W];
                hab_d[i]     = habilita_i[i];
                atual_d[i]   = passo_rampa(atual_q[i], posicao_i[i*W +: W]);
                largura_d[i] = LMIN_W + LW'(atual_d[i]) * PASSO_W;
                pronto_d[i]  = (atual_d[i] == posicao_i[i*W +: W]);
            end
            // Output is registered: it reflects the counter value it will sit beside.
            sinal_d[i] = hab_d[i] && (LW'(contador_d) < largura_d[i]);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            contador_q <= '0;
            fim_q      <= 1'b0;
            hab_q      <= '0;
            sinal_q    <= '0;
            pronto_q   <= '1;
            for (int i = 0; i < N; i++) begin
                atual_q[i]   <= '0;
                alvo_q[i]    <= '0;
                largura_q[i] <= LMIN_W;
            end
        end else begin
            contador_q <= contador_d;
            fim_q      <= fim_d;
            hab_q      <= hab_d;
            sinal_q    <= sinal_d;
            pronto_q   <= pronto_d;
            for (int i = 0; i < N; i++) begin
                atual_q[i]   <= atual_d[i];
                alvo_q[i]    <= alvo_d[i];
                largura_q[i] <= largura_d[i];
            end
        end
    end

    assign sinal_controle_o = sinal_q;
    assign pronto_o         = pronto_q;
    assign fim_periodo_o    = fim_q;

endmodule

// File: doc/controle_servo_multi.md
Name: controle_servo_multi

Overview:
Parametrised successor to the single-channel servo PWM controller. It drives N servo channels from one shared period counter (default 20 ms @ 50 MHz). Each channel has a W-bit position, an independent enable and slew-rate limiting: the applied position ramps toward the target by at most RAMPA units per period. It sits between the sonar control FSM and the servo pins, and reports per-channel settle status so the FSM can wait for the servo to reach position before measuring.

Parameters:
N, 2, number of servo channels
W, 8, position width in bits
PERIODO, 1_000_000, PWM period in clock cycles (20 ms @ 50 MHz)
LARGURA_MIN, 50_000, pulse width in cycles at position 0 (1 ms)
PASSO, 196, additional pulse cycles per position unit (255 -> 99_980 cycles ≈ 2 ms)
RAMPA, 4, maximum position change per period; 0 = no limit (jump directly)

Ports:
clock  in  1  system clock
reset  in  1  synchronous reset, active-high
posicao  in  N*W  target positions; channel i = bits [i*W+W-1 : i*W]
habilita  in  N  per-channel pulse enable
sinal_controle  out  N  PWM outputs, registered
pronto  out  N  channel i applied position equals its latched target
fim_periodo  out  1  one-cycle pulse on the last cycle of each period

Behaviour:
- Reset: synchronous, active-high; takes priority over everything. Clears period counter to 0, every atual_i (applied position) to 0, every alvo_i (latched target) to 0, every hab_i (latched enable) to 0, sinal_controle=0, pronto=all 1s, fim_periodo=0. Reset asserted mid-pulse forces sinal_controle low on the next edge.
- Period counter: counts 0..PERIODO-1 and wraps. fim_periodo=1 exactly when the counter is PERIODO-1.
- Period boundary, at the edge leaving counter=PERIODO-1, per channel:
  - alvo_i <= posicao_i; hab_i <= habilita_i. Sample is taken only here; input changes mid-period have no effect until the next boundary.
  - atual_i steps toward the newly sampled target:
    - if RAMPA=0 or |posicao_i - atual_i| <= RAMPA: atual_i <= posicao_i;
    - else atual_i <= atual_i ± RAMPA.
    - Comparison uses W+1-bit unsigned arithmetic; no wrap-around is possible.
  - largura_i <= LARGURA_MIN + atual_i(new)*PASSO, computed in a width sufficient for PERIODO.
- Output: during the period that follows, sinal_controle[i] is high for exactly largura_i consecutive cycles, starting the cycle after fim_periodo, when hab_i=1. It stays low for the whole period when hab_i=0. Pulse width never changes mid-period.
- First period after reset: hab_i=0, so there are no pulses until the first boundary.
- pronto[i] is registered and equals (atual_i == alvo_i). It updates on the same edge as atual_i. It does not depend on habilita.
- Target reversal mid-ramp: the step direction follows the latest sampled target; no overshoot.
- Simultaneous boundary and reset: reset wins.
- Design constraint, checked by bench assertion: LARGURA_MIN + (2^W-1)*PASSO < PERIODO.

Test Plan:
Benches use N=2, W=4, PERIODO=1000, LARGURA_MIN=50, PASSO=2, RAMPA=3.
1. Reset pulse, habilita=00, posicao=0 -> both outputs low for 3 full periods; pronto=11; fim_periodo pulses every 1000 cycles.
2. habilita=01, ch0 target 10 from 0 -> successive ch0 pulse widths 56, 62, 68, 70, 70 cycles; pronto[0]=0 until the period with width 70, then 1.
3. ch0 at 10, target changed to 2 mid-period -> current pulse stays 70; next periods 64, 58, 54 cycles; ch1 (habilita=0) stays low throughout.
4. Both channels enabled, ch0 target 15, ch1 target 1 -> ch1 reaches 52 in the first period with pronto[1]=1; ch0 ramps 56, 62, 68, 74, 80; outputs are independent and both start the cycle after fim_periodo.
5. Rebuild with RAMPA=0, target 0 -> 15 -> next period width 80; pronto=1 immediately.
6. Assert reset halfway through a 70-cycle pulse -> output low next cycle; counter 0; following period has no pulse; atual=0, so the ramp restarts from 0 (56 first).
